// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } div_state_t;

    localparam int              DIV_W      = 16;
    localparam logic [DIV_W-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, then subtract the divisor if it fits.
module div_restore_step
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W-1:0] rem,
    input  logic         msb,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);

    // One extra bit so the shifted remainder never wraps before the compare.
    logic [W:0] shifted;

    always_comb begin
        shifted  = {rem, msb};
        q_bit    = (shifted >= {1'b0, divisor});
        rem_next = q_bit ? W'(shifted - {1'b0, divisor}) : shifted[W-1:0];
    end

endmodule

// File: rtl/iter_divider.sv
// Radix-2 iterative restoring divider: dividend / divisor -> quotient, remainder.
// Define DIV_SIGNED_EN for two's-complement operands (truncating division).
module iter_divider
    import div_pkg::*;
#(
    parameter int W     = DIV_W,
    parameter int CNT_W = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         done,
    output logic         busy,
    output logic         div_zero
);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [W-1:0]     rem_q, rem_d;
    logic [W-1:0]     q_q, q_d;
    logic [W-1:0]     dvsr_q, dvsr_d;
    logic             zero_pend_q, zero_pend_d;
    logic [W-1:0]     quotient_d, remainder_d;
    logic             done_d, div_zero_d;
    logic [W-1:0]     step_rem, q_shift;
    logic             step_q;

`ifdef DIV_SIGNED_EN
    logic neg_quot_q, neg_quot_d;
    logic neg_rem_q, neg_rem_d;

    function automatic logic [W-1:0] mag(input logic [W-1:0] v);
        return v[W-1] ? W'(-v) : v;
    endfunction
`endif

    div_restore_step #(.W(W)) u_step (
        .rem      (rem_q),
        .msb      (q_q[W-1]),
        .divisor  (dvsr_q),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    assign busy = (state_q == RUN);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        q_d         = q_q;
        dvsr_d      = dvsr_q;
        zero_pend_d = 1'b0;
        quotient_d  = quotient;
        remainder_d = remainder;
        done_d      = done;
        div_zero_d  = div_zero;
        q_shift     = {q_q[W-2:0], step_q};
`ifdef DIV_SIGNED_EN
        neg_quot_d  = neg_quot_q;
        neg_rem_d   = neg_rem_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (zero_pend_q) begin
                    // Divide-by-zero result lands one edge after acceptance.
                    quotient_d  = '1;
                    remainder_d = q_q;
                    div_zero_d  = 1'b1;
                    done_d      = 1'b1;
                end else if (start) begin
                    done_d     = 1'b0;
                    div_zero_d = 1'b0;
                    if (divisor == '0) begin
                        zero_pend_d = 1'b1;
                        q_d         = dividend;
                    end else begin
                        state_d = RUN;
                        count_d = '0;
                        rem_d   = '0;
`ifdef DIV_SIGNED_EN
                        q_d        = mag(dividend);
                        dvsr_d     = mag(divisor);
                        neg_quot_d = dividend[W-1] ^ divisor[W-1];
                        neg_rem_d  = dividend[W-1];
`else
                        q_d    = dividend;
                        dvsr_d = divisor;
`endif
                    end
                end
            end
            RUN: begin
                rem_d   = step_rem;
                q_d     = q_shift;
                count_d = count_q + 1'b1;
                if (count_q == CNT_W'(W - 1)) begin
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    div_zero_d = 1'b0;
`ifdef DIV_SIGNED_EN
                    quotient_d  = neg_quot_q ? W'(-q_shift)  : q_shift;
                    remainder_d = neg_rem_q  ? W'(-step_rem) : step_rem;
`else
                    quotient_d  = q_shift;
                    remainder_d = step_rem;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: reset clears every register, so an aborted run leaves no stale operands behind.
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            q_q         <= '0;
            dvsr_q      <= '0;
            zero_pend_q <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_zero    <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            q_q         <= q_d;
            dvsr_q      <= dvsr_d;
            zero_pend_q <= zero_pend_d;
            quotient    <= quotient_d;
            remainder   <= remainder_d;
            done        <= done_d;
            div_zero    <= div_zero_d;
`ifdef DIV_SIGNED_EN
            neg_quot_q  <= neg_quot_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed cases plus randomized operands
// against a plain-arithmetic reference model (honours DIV_SIGNED_EN).
module tb_iter_divider;
    import div_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend, divisor;
    logic [W-1:0] quotient, remainder;
    logic         done, busy, div_zero;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } res_t;

    iter_divider #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done),
        .busy      (busy),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t x;
`ifdef DIV_SIGNED_EN
        int sa, sb;
`endif
        if (b == '0) begin
            x.q  = DIV_ZERO_Q;
            x.r  = a;
            x.dz = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            sa   = int'($signed(a));
            sb   = int'($signed(b));
            x.q  = W'(sa / sb);
            x.r  = W'(sa % sb);
`else
            x.q  = a / b;
            x.r  = a % b;
`endif
            x.dz = 1'b0;
        end
        return x;
    endfunction

    // Reference model: edges remaining until the result appears.
    int   m_left;
    bit   m_busy, m_done, m_fresh;
    res_t m_res, m_pend;

    always @(posedge clk) begin
        if (rst) begin
            m_left  <= 0;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_fresh <= 1'b1;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_res  <= m_pend;
            end
        end else if (start) begin
            m_done  <= 1'b0;
            m_fresh <= 1'b0;
            m_pend  <= ref_div(dividend, divisor);
            m_left  <= (divisor == '0) ? 1 : W;
            m_busy  <= (divisor != '0);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_done", 32'(done), 32'(m_done));
            check("cyc_busy", 32'(busy), 32'(m_busy));
            if (m_done) begin
                check("cyc_quotient", 32'(quotient), 32'(m_res.q));
                check("cyc_remainder", 32'(remainder), 32'(m_res.r));
                check("cyc_div_zero", 32'(div_zero), 32'(m_res.dz));
            end else if (m_fresh) begin
                check("cyc_rst_quotient", 32'(quotient), 32'h0);
                check("cyc_rst_remainder", 32'(remainder), 32'h0);
                check("cyc_rst_div_zero", 32'(div_zero), 32'h0);
            end
        end
    end

    // Issue one operation; optionally scramble operands and pulse spurious starts while busy.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble,
                          output int lat, output bit busy_seen);
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        busy_seen = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_clear_on_accept", 32'(done), 32'h0);
        lat = 0;
        while (1) begin
            if (scramble) begin
                dividend = W'($urandom);
                divisor  = W'($urandom);
                if (b != '0) start = ($urandom_range(0, 3) == 0);
            end
            @(posedge clk);
            #1;
            lat++;
            busy_seen |= busy;
            if (done) break;
            if (lat >= 64) begin
                check("done_timeout", 32'(lat), 32'(W));
                break;
            end
        end
        start = 1'b0;
        check("latency", 32'(lat), (b == '0) ? 32'd1 : 32'(W));
    endtask

    initial begin
        int   lat;
        bit   bs;
        res_t pin;
        logic [W-1:0] a, b;

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;

        // Pin the reference model itself with hand-computed results.
        pin = ref_div(16'h0064, 16'h0007);
        check("model_100_7_q", 32'(pin.q), 32'h000E);
        check("model_100_7_r", 32'(pin.r), 32'h0002);
        pin = ref_div(16'd1000, 16'd3);
        check("model_1000_3_q", 32'(pin.q), 32'h014D);
        pin = ref_div(16'h0005, 16'h0000);
        check("model_5_0_q", 32'(pin.q), 32'hFFFF);
        check("model_5_0_dz", 32'(pin.dz), 32'h1);

        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        cmp_en = 1'b1;
        check("reset_done", 32'(done), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_quotient", 32'(quotient), 32'h0);

        // 100 / 7
        run_op(16'h0064, 16'h0007, 1'b0, lat, bs);
        check("t1_quotient", 32'(quotient), 32'h000E);
        check("t1_remainder", 32'(remainder), 32'h0002);
        check("t1_div_zero", 32'(div_zero), 32'h0);

        // 5 / 0
        run_op(16'h0005, 16'h0000, 1'b0, lat, bs);
        check("t2_quotient", 32'(quotient), 32'hFFFF);
        check("t2_remainder", 32'(remainder), 32'h0005);
        check("t2_div_zero", 32'(div_zero), 32'h1);
        check("t2_busy_never", 32'(bs), 32'h0);

        // Back-to-back, second start issued while done=1.
        run_op(16'hFFFF, 16'h0001, 1'b0, lat, bs);
        check("t3a_quotient", 32'(quotient), 32'hFFFF);
        check("t3a_remainder", 32'(remainder), 32'h0000);
        run_op(16'h0003, 16'h0009, 1'b0, lat, bs);
        check("t3b_quotient", 32'(quotient), 32'h0000);
        check("t3b_remainder", 32'(remainder), 32'h0003);

        // Spurious start at cycle 6 of a run is ignored.
        dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        dividend = 16'd50; divisor = 16'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 6;
        while (!done && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("t4_latency", 32'(lat), 32'(W));
        check("t4_quotient", 32'(quotient), 32'h014D);
        check("t4_remainder", 32'(remainder), 32'h0001);

        // Reset in the middle of a run aborts it.
        dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_done", 32'(done), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_quotient", 32'(quotient), 32'h0);
        check("t5_remainder", 32'(remainder), 32'h0);
        check("t5_div_zero", 32'(div_zero), 32'h0);
        run_op(16'd9, 16'd3, 1'b0, lat, bs);
        check("t5_quotient_9_3", 32'(quotient), 32'h0003);
        check("t5_remainder_9_3", 32'(remainder), 32'h0000);

`ifdef DIV_SIGNED_EN
        run_op(16'hFFF9, 16'h0002, 1'b0, lat, bs);
        check("t6a_quotient", 32'(quotient), 32'hFFFD);
        check("t6a_remainder", 32'(remainder), 32'hFFFF);
        run_op(16'h8000, 16'hFFFF, 1'b0, lat, bs);
        check("t6b_quotient", 32'(quotient), 32'h8000);
        check("t6b_remainder", 32'(remainder), 32'h0000);
`endif

        // Randomized operands, including zero and boundary divisors.
        for (int i = 0; i < 150; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 4))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = W'($urandom_range(0, 1)) ? 16'hFFFF : 16'h8000;
                default: b = W'($urandom);
            endcase
            if (b == '0 && $urandom_range(0, 1) == 0) b = 16'h0001;
            run_op(a, b, $urandom_range(0, 1) == 1, lat, bs);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (2) @(posedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
